// File: rtl/date_set_ctl.sv
// date_set_ctl: BCD calendar date with RUN/SET mode FSM, field editing and blink masking.
// Optional macro LEAP_YEAR_EN enables 29-day February in years divisible by 4.
module date_set_ctl (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       blink,
  output logic [1:0] mode,
  output logic [3:0] day1,
  output logic [3:0] day0,
  output logic [3:0] month1,
  output logic [3:0] month0,
  output logic [3:0] year1,
  output logic [3:0] year0,
  output logic [2:0] field_blank
);
  typedef enum logic [1:0] {RUN, SET_YEAR, SET_MONTH, SET_DAY} state_e;

  state_e     r_state, w_state_n;
  logic [7:0] r_day, r_month, r_year;
  logic [7:0] w_day_n, w_month_n, w_year_n, w_day_clamped;
  logic [7:0] w_max_cur, w_max_new;
  logic       w_leap_cur, w_leap_new, w_edit;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] max_day(input logic [7:0] m, input logic leap);
    case (m)
      8'h02:                      return leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

`ifdef LEAP_YEAR_EN
  function automatic logic is_leap(input logic [7:0] y);
    return y[4] ? (y[3:0] == 4'd2 || y[3:0] == 4'd6)
                : (y[3:0] == 4'd0 || y[3:0] == 4'd4 || y[3:0] == 4'd8);
  endfunction
  assign w_leap_cur = is_leap(r_year);
  assign w_leap_new = is_leap(w_year_n);
`else
  assign w_leap_cur = 1'b0;
  assign w_leap_new = 1'b0;
`endif

  assign w_max_cur = max_day(r_month, w_leap_cur);
  assign w_max_new = max_day(w_month_n, w_leap_new);
  assign w_edit    = inc_btn && !mode_btn;

  always_comb begin
    w_state_n = mode_btn ? state_e'(r_state + 2'd1) : r_state;
  end

  always_comb begin
    w_day_n   = r_day;
    w_month_n = r_month;
    w_year_n  = r_year;
    case (r_state)
      RUN: if (tick) begin
        if (r_day == w_max_cur) begin
          w_day_n = 8'h01;
          if (r_month == 8'h12) begin
            w_month_n = 8'h01;
            w_year_n  = (r_year == 8'h99) ? 8'h00 : bcd_inc(r_year);
          end else begin
            w_month_n = bcd_inc(r_month);
          end
        end else begin
          w_day_n = bcd_inc(r_day);
        end
      end
      SET_YEAR:  if (w_edit) w_year_n  = (r_year == 8'h99) ? 8'h00 : bcd_inc(r_year);
      SET_MONTH: if (w_edit) w_month_n = (r_month == 8'h12) ? 8'h01 : bcd_inc(r_month);
      SET_DAY:   if (w_edit) w_day_n   = (r_day == w_max_cur) ? 8'h01 : bcd_inc(r_day);
      default: ;
    endcase
  end

  // packed BCD orders like binary, so a plain compare clamps the day
  assign w_day_clamped = (w_day_n > w_max_new) ? w_max_new : w_day_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_day   <= 8'h01;
      r_month <= 8'h01;
      r_year  <= 8'h00;
    end else begin
      r_state <= w_state_n;
      r_day   <= w_day_clamped;
      r_month <= w_month_n;
      r_year  <= w_year_n;
    end
  end

  assign mode   = r_state;
  assign day1   = r_day[7:4];
  assign day0   = r_day[3:0];
  assign month1 = r_month[7:4];
  assign month0 = r_month[3:0];
  assign year1  = r_year[7:4];
  assign year0  = r_year[3:0];

  always_comb begin
    field_blank = (r_state == SET_YEAR)  ? {blink, 2'b00} :
                  (r_state == SET_MONTH) ? {1'b0, blink, 1'b0} :
                  (r_state == SET_DAY)   ? {2'b00, blink} : 3'b000;
  end
endmodule

// File: doc/date_set_ctl.md
DATE_SET_CTL -- requirements
Module: date_set_ctl

Interface
REQ-001 The block SHALL have the port `clk`: input, 1 bit, the single clock; all state SHALL change on its rising edge.
REQ-002 The block SHALL have the port `rst`: input, 1 bit, asynchronous active-low reset.
REQ-003 The block SHALL have the port `tick`: input, 1 bit, one-cycle date-advance strobe (divided time base).
REQ-004 The block SHALL have the port `mode_btn`: input, 1 bit, debounced one-cycle pulse that steps the mode.
REQ-005 The block SHALL have the port `inc_btn`: input, 1 bit, debounced one-cycle pulse that increments the selected field.
REQ-006 The block SHALL have the port `blink`: input, 1 bit, slow square wave used for field blinking.
REQ-007 The block SHALL have the port `mode`: output, 2 bits: 00 RUN, 01 SET_YEAR, 10 SET_MONTH, 11 SET_DAY.
REQ-008 The block SHALL have the ports `day1`, `day0`, `month1`, `month0`, `year1`, `year0`: outputs, 4 bits each, BCD tens/units digits of the date.
REQ-009 The block SHALL have the port `field_blank`: output, 3 bits; [2] year, [1] month, [0] day; 1 means blank that field.

Function
REQ-010 The date SHALL be held internally as BCD: day 01..max, month 01..12, year 00..99.
REQ-011 max_day SHALL be 31 for months 1,3,5,7,8,10,12, 30 for months 4,6,9,11, and 28 for month 2 (29 under REQ-027).
REQ-012 The mode FSM SHALL step on `mode_btn`: RUN->SET_YEAR->SET_MONTH->SET_DAY->RUN; with no `mode_btn` it SHALL hold its state.
REQ-013 In RUN, `tick` SHALL advance the day by one at the same clock edge.
REQ-014 In RUN, when the day equals max_day, `tick` SHALL set the day to 01 and increment the month.
REQ-015 In RUN, when the month is 12 at that rollover, the month SHALL become 01 and the year SHALL increment.
REQ-016 In RUN, year 99 SHALL wrap to 00.
REQ-017 In all SET states, `tick` SHALL be ignored and the date SHALL be frozen except for `inc_btn` edits.
REQ-018 In SET_YEAR, `inc_btn` SHALL increment the year, wrapping 99->00.
REQ-019 In SET_MONTH, `inc_btn` SHALL increment the month, wrapping 12->01.
REQ-020 In SET_DAY, `inc_btn` SHALL increment the day, wrapping max_day->01.
REQ-021 When a year or month edit lowers max_day below the current day, the day SHALL be clamped to the new max_day at the same edge.
REQ-022 When `mode_btn` and `inc_btn` are asserted in the same cycle, `mode_btn` SHALL win and `inc_btn` SHALL be ignored.
REQ-023 When `tick` and `mode_btn` are asserted in the same cycle in RUN, the date SHALL advance and the mode SHALL become SET_YEAR at the same edge.
REQ-024 Latency SHALL be one edge: an input sampled at edge k SHALL be visible on the outputs after edge k.
REQ-025 `field_blank` SHALL be combinational from the registered `mode` and `blink`: the bit of the selected field equals `blink`, all other bits 0; in RUN it SHALL be 000.

Reset
REQ-026 While `rst`=0, independent of `clk` and including mid-edit, the block SHALL force: mode=RUN, day=01, month=01, year=00 (day1=0, day0=1, month1=0, month0=1, year1=0, year0=0), field_blank=000; after reset release, normal operation SHALL start at the first rising edge.

Configuration
REQ-027 With macro LEAP_YEAR_EN defined, February max_day SHALL be 29 when the year is divisible by 4 (tens even and units in {0,4,8}, or tens odd and units in {2,6}); without it, February max_day SHALL always be 28.

Verification
REQ-028 Reset in SET_MONTH with month=07 -> outputs immediately 01/01/00, mode=00.
REQ-029 RUN, date 31/12/99, one `tick` -> 01/01/00.
REQ-030 RUN, date 28/02/24, one `tick` -> 29/02/24 with LEAP_YEAR_EN defined, 01/03/24 without it.
REQ-031 SET_DAY, day=31, month=03, `inc_btn` -> day 01; then mode to SET_MONTH is not allowed here, so instead from SET_MONTH with day=31, month=03, `inc_btn` -> month 04, day 30.
REQ-032 SET_YEAR, `mode_btn`+`inc_btn` in the same cycle -> mode=10, year unchanged; `tick` pulses while in SET_* -> date unchanged.
REQ-033 SET_MONTH with blink=1 -> field_blank=010; blink=0 -> 000; in RUN with blink=1 -> 000.
